// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Zero-latency lookup for fetch; update/recovery port for resolve.
module branch_predictor #(
    parameter int         PC_WIDTH   = 32,
    parameter int         INDEX_BITS = 4,
    parameter logic [1:0] CTR_INIT   = 2'b01,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_all,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 update_valid,
    input  logic [PC_WIDTH-1:0]  update_pc,
    input  logic                 update_taken,
    input  logic [PC_WIDTH-1:0]  update_target,
    input  logic                 update_pred_taken,
    input  logic [PC_WIDTH-1:0]  update_pred_target,
    output logic                 mispredict,
    output logic [PC_WIDTH-1:0]  recover_pc,
    output logic [CNT_WIDTH-1:0] lookup_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_WIDTH - INDEX_BITS;

    logic                entry_valid  [ENTRIES];
    logic [TAG_W-1:0]    entry_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] entry_target [ENTRIES];
    logic [1:0]          entry_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] l_idx;
    logic [TAG_W-1:0]      l_tag;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  u_hit;

    function automatic logic [1:0] ctr_step(input logic [1:0] c,
                                            input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11)
            r = c + 2'd1;
        else if (!up && c != 2'b00)
            r = c - 2'd1;
        return r;
    endfunction

    assign l_idx = lookup_pc[INDEX_BITS-1:0];
    assign l_tag = lookup_pc[PC_WIDTH-1:INDEX_BITS];
    assign u_idx = update_pc[INDEX_BITS-1:0];
    assign u_tag = update_pc[PC_WIDTH-1:INDEX_BITS];

    assign pred_hit    = entry_valid[l_idx] && (entry_tag[l_idx] == l_tag);
    assign pred_taken  = pred_hit && entry_ctr[l_idx][1];
    assign pred_target = pred_taken ? entry_target[l_idx]
                                    : lookup_pc + PC_WIDTH'(1);

    assign u_hit = entry_valid[u_idx] && (entry_tag[u_idx] == u_tag);

    assign mispredict = update_valid &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken &&
                          (update_target != update_pred_target)));
    assign recover_pc = update_taken ? update_target
                                     : update_pc + PC_WIDTH'(1);

    // Flush wins over a same-cycle update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i]  <= 1'b0;
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
                entry_ctr[i]    <= CTR_INIT;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ctr[i]   <= CTR_INIT;
            end
        end else if (update_valid) begin
            unique case (1'b1)
                u_hit: begin
                    entry_ctr[u_idx] <= ctr_step(entry_ctr[u_idx],
                                                 update_taken);
                    if (update_taken)
                        entry_target[u_idx] <= update_target;
                end
                (!u_hit && update_taken): begin
                    entry_valid[u_idx]  <= 1'b1;
                    entry_tag[u_idx]    <= u_tag;
                    entry_target[u_idx] <= update_target;
                    entry_ctr[u_idx]    <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lookup_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (lookup_valid)
                lookup_count <= lookup_count + CNT_WIDTH'(1);
            if (mispredict)
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
// Expectations are queued per cycle and checked on the falling edge.
module tb_branch_predictor;

    localparam int S_HIT = 0, S_TKN = 1, S_TGT = 2, S_MIS = 3;
    localparam int S_REC = 4, S_LCNT = 5, S_MCNT = 6;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic        clock, reset, flush_all, lookup_valid;
    logic [31:0] lookup_pc, pred_target;
    logic        pred_hit, pred_taken;
    logic        update_valid, update_taken, update_pred_taken;
    logic [31:0] update_pc, update_target, update_pred_target;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [15:0] lookup_count, mispredict_count;

    chk_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    branch_predictor dut (
        .clock              (clock),
        .reset              (reset),
        .flush_all          (flush_all),
        .lookup_valid       (lookup_valid),
        .lookup_pc          (lookup_pc),
        .pred_hit           (pred_hit),
        .pred_taken         (pred_taken),
        .pred_target        (pred_target),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .mispredict         (mispredict),
        .recover_pc         (recover_pc),
        .lookup_count       (lookup_count),
        .mispredict_count   (mispredict_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_HIT:   return {31'b0, pred_hit};
            S_TKN:   return {31'b0, pred_taken};
            S_TGT:   return pred_target;
            S_MIS:   return {31'b0, mispredict};
            S_REC:   return recover_pc;
            S_LCNT:  return {16'b0, lookup_count};
            default: return {16'b0, mispredict_count};
        endcase
    endfunction

    // Monitor: drains every expectation due by this cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            chk_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h",
                         e.name, a, e.exp);
            end
        end
    end

    task automatic want(input string n, input int s,
                        input logic [31:0] v);
        q.push_back('{cyc, n, s, v});
    endtask

    task automatic drive(input logic lv, input logic [31:0] lpc,
                         input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt,
                         input logic upt, input logic [31:0] uptgt,
                         input logic fl);
        @(posedge clock);
        #1;
        lookup_valid       = lv;
        lookup_pc          = lpc;
        update_valid       = uv;
        update_pc          = upc;
        update_taken       = ut;
        update_target      = utgt;
        update_pred_taken  = upt;
        update_pred_target = uptgt;
        flush_all          = fl;
    endtask

    task automatic idle(input logic [31:0] lpc);
        drive(0, lpc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        flush_all = 0; lookup_valid = 0; lookup_pc = 32'h40;
        update_valid = 0; update_pc = 0; update_taken = 0;
        update_target = 0; update_pred_taken = 0;
        update_pred_target = 0;

        // reset state
        @(posedge clock);
        #1;
        want("rst_hit", S_HIT, 0);
        want("rst_tkn", S_TKN, 0);
        want("rst_tgt", S_TGT, 32'h41);
        want("rst_lcnt", S_LCNT, 0);
        want("rst_mcnt", S_MCNT, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // allocate on mispredicted taken branch
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        want("t1_lcnt", S_LCNT, 0);
        drive(0, 32'h40, 1, 32'h40, 1, 32'h10, 0, 32'h41, 0);
        want("t2_mis", S_MIS, 1);
        want("t2_rec", S_REC, 32'h10);
        want("t2_old_hit", S_HIT, 0);
        want("t2_lcnt", S_LCNT, 1);
        idle(32'h40);
        want("t2_hit", S_HIT, 1);
        want("t2_tkn", S_TKN, 1);
        want("t2_tgt", S_TGT, 32'h10);
        want("t2_mcnt", S_MCNT, 1);
        want("t2_nomis", S_MIS, 0);

        // saturate high: 10 -> 11 and stays
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h40, 1, 32'h40, 1, 32'h10, 1, 32'h10, 0);
            want("t3_up_mis", S_MIS, 0);
        end
        // not-taken steps 11 -> 10 -> 01 -> 00 -> 00 -> 00
        drive(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h41, 0);
        want("t3_nt1", S_TKN, 1);
        want("t3_rec", S_REC, 32'h41);
        drive(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h41, 0);
        want("t3_nt2", S_TKN, 1);
        drive(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h41, 0);
        want("t3_nt3", S_TKN, 0);
        drive(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h41, 0);
        want("t3_nt4", S_TKN, 0);
        drive(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h41, 0);
        want("t3_nt5", S_TKN, 0);
        idle(32'h40);
        want("t3_hit", S_HIT, 1);
        want("t3_tkn", S_TKN, 0);
        want("t3_tgt", S_TGT, 32'h41);
        want("t3_mcnt", S_MCNT, 1);

        // wrong target: mispredict, ctr 00 -> 01, target now 0x20
        drive(0, 32'h40, 1, 32'h40, 1, 32'h20, 1, 32'h10, 0);
        want("tgt_mis", S_MIS, 1);
        want("tgt_rec", S_REC, 32'h20);
        idle(32'h40);
        want("tgt_tkn", S_TKN, 0);
        want("tgt_mcnt", S_MCNT, 2);
        drive(0, 32'h40, 1, 32'h40, 1, 32'h20, 1, 32'h20, 0);
        want("tgt_nomis", S_MIS, 0);
        idle(32'h40);
        want("tgt_tkn2", S_TKN, 1);
        want("tgt_new", S_TGT, 32'h20);

        // alias 0x50 replaces 0x40 at index 0
        drive(0, 32'h50, 1, 32'h50, 1, 32'h33, 0, 32'h51, 0);
        want("al_same_cyc", S_HIT, 0);
        want("al_mcnt", S_MCNT, 2);
        idle(32'h40);
        want("al_old_miss", S_HIT, 0);
        want("al_old_tgt", S_TGT, 32'h41);
        want("al_mcnt2", S_MCNT, 3);
        drive(0, 32'h50, 1, 32'h50, 1, 32'h44, 1, 32'h33, 0);
        want("al_hit", S_HIT, 1);
        want("al_tkn", S_TKN, 1);
        want("al_pre_tgt", S_TGT, 32'h33);
        idle(32'h50);
        want("al_post_tgt", S_TGT, 32'h44);
        want("al_mcnt3", S_MCNT, 4);

        // miss and not-taken leaves no entry
        drive(0, 32'h23, 1, 32'h23, 0, 0, 0, 32'h24, 0);
        idle(32'h23);
        want("nt_noalloc", S_HIT, 0);

        // flush beats a same-cycle update
        drive(1, 32'h50, 1, 32'h61, 1, 32'h7, 1, 32'h7, 1);
        want("fl_pre_hit", S_HIT, 1);
        idle(32'h61);
        want("fl_upd_miss", S_HIT, 0);
        want("fl_lcnt", S_LCNT, 2);
        idle(32'h50);
        want("fl_miss", S_HIT, 0);
        want("fl_tkn", S_TKN, 0);
        want("fl_mcnt", S_MCNT, 4);

        // async reset during an update
        drive(0, 32'h40, 1, 32'h40, 1, 32'h10, 1, 32'h10, 0);
        idle(32'h40);
        want("ar_pre_hit", S_HIT, 1);
        drive(1, 32'h40, 1, 32'h40, 1, 32'h10, 0, 32'h41, 0);
        #1;
        reset = 1'b0;
        want("ar_hit", S_HIT, 0);
        want("ar_tgt", S_TGT, 32'h41);
        want("ar_lcnt", S_LCNT, 0);
        want("ar_mcnt", S_MCNT, 0);
        drive(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        want("ar_held", S_HIT, 0);
        want("ar_held_lcnt", S_LCNT, 0);

        // lookup_count wrap
        for (int i = 0; i < 65535; i++)
            drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        idle(32'h0);
        want("wrap_max", S_LCNT, 32'hFFFF);
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        idle(32'h0);
        want("wrap_zero", S_LCNT, 0);

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
